// File: rtl/ext_mem_responder.sv
// ext_mem_responder: wait-state target for the CPU external memory bus, backed by a word array.
// Define EXT_MEM_STATS_EN to add saturating rd_count/wr_count/err_count outputs.
module ext_mem_responder #(
    parameter logic [31:0] EXT_BASE    = 32'h0010_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_data_in,
    output logic [31:0] ext_data_out,
    output logic        ext_data_oe,
    input  logic        ext_mem_read,
    input  logic        ext_mem_write,
    input  logic        ext_mem_enable,
    output logic        ext_mem_ready,
    output logic        bus_error,
    output logic        busy
`ifdef EXT_MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [7:0]  err_count
`endif
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [7:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        dout_q, dout_d;
    logic               ready_q, ready_d, oe_q, oe_d, berr_q, berr_d;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        offset;
    logic               req, in_err, same_req, cap, enter_ack, hold, mem_we;

    assign req      = ext_mem_enable & (ext_mem_read | ext_mem_write);
    assign offset   = ext_addr - EXT_BASE;
    // Range check on the unshifted offset so nothing past the array aliases back in.
    assign in_err   = (ext_addr < EXT_BASE) | (offset >= SPAN) | (ext_mem_read & ext_mem_write);
    assign same_req = (ext_addr[31:2] == addr_q) & (ext_mem_read == rd_q) & (ext_mem_write == wr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cap     = 1'b1;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (!same_req) begin
                    cap     = 1'b1;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
                    cnt_d   = WAIT_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready/oe/error lag ACK entry by one clock so data is settled before ready rises.
    always_comb begin
        rd_d      = cap ? ext_mem_read : rd_q;
        wr_d      = cap ? ext_mem_write : wr_q;
        err_d     = cap ? in_err : err_q;
        idx_d     = cap ? offset[IDX_W+1:2] : idx_q;
        addr_d    = cap ? ext_addr[31:2] : addr_q;
        wdata_d   = cap ? ext_data_in : wdata_q;
        enter_ack = (state_d == ST_ACK) & ((state_q != ST_ACK) | cap);
        hold      = (state_q == ST_ACK) & (state_d == ST_ACK) & ~cap;
        mem_we    = enter_ack & wr_d & ~rd_d & ~err_d;
        ready_d   = hold;
        oe_d      = hold & rd_q;
        berr_d    = hold & err_q;
        dout_d    = dout_q;
        if (enter_ack && rd_d) begin
            dout_d = err_d ? ERR_DATA : mem[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign ext_data_out  = dout_q;
    assign ext_data_oe   = oe_q;
    assign ext_mem_ready = ready_q;
    assign bus_error     = berr_q;
    assign busy          = (state_q == ST_WAIT);

`ifdef EXT_MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic [7:0]  err_count_q, err_count_d;

    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (enter_ack && err_d && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
        if (enter_ack && !err_d && rd_d && rd_count_q != 16'hFFFF) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (mem_we && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed self-checking bench for ext_mem_responder: one instance with 2 wait states, one with none.
module tb_ext_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, din, dout;
    logic        rd, wr, en, oe, ready, berr, busy;
    logic [31:0] addr0, din0, dout0;
    logic        rd0, wr0, en0, oe0, ready0, berr0, busy0;
`ifdef EXT_MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
    logic [7:0]  err_cnt, err_cnt0;
`endif
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ext_mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ext_addr(addr), .ext_data_in(din), .ext_data_out(dout),
        .ext_data_oe(oe), .ext_mem_read(rd), .ext_mem_write(wr), .ext_mem_enable(en),
        .ext_mem_ready(ready), .bus_error(berr), .busy(busy)
`ifdef EXT_MEM_STATS_EN
        , .rd_count(rd_cnt), .wr_count(wr_cnt), .err_count(err_cnt)
`endif
    );

    ext_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ext_addr(addr0), .ext_data_in(din0), .ext_data_out(dout0),
        .ext_data_oe(oe0), .ext_mem_read(rd0), .ext_mem_write(wr0), .ext_mem_enable(en0),
        .ext_mem_ready(ready0), .bus_error(berr0), .busy(busy0)
`ifdef EXT_MEM_STATS_EN
        , .rd_count(rd_cnt0), .wr_count(wr_cnt0), .err_count(err_cnt0)
`endif
    );

    function automatic logic [31:0] bus();
        return {28'd0, ready, oe, berr, busy};
    endfunction

    function automatic logic [31:0] bus0();
        return {28'd0, ready0, oe0, berr0, busy0};
    endfunction

    task automatic stepClock(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        en = e; rd = r; wr = w; addr = a; din = d;
    endtask

    task automatic applyStimulus0(input logic e, input logic r, input logic w,
                                  input logic [31:0] a, input logic [31:0] d);
        en0 = e; rd0 = r; wr0 = w; addr0 = a; din0 = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus word is {ready, oe, bus_error, busy}; ready is due 3 clocks after capture.
    task automatic runAccess(input string tag, input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_bus, input logic [31:0] exp_data);
        applyStimulus(1'b1, r, w, a, d);
        stepClock(4);
        checkOutput({tag, "_bus"}, bus(), exp_bus);
        if (r) checkOutput({tag, "_data"}, dout, exp_data);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1);
        checkOutput({tag, "_idle"}, bus(), 32'b0000);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(2);
        checkOutput("reset_bus", bus(), 32'b0000);
        checkOutput("reset_data", dout, 32'h0);
        checkOutput("reset_bus0", bus0(), 32'b0000);
`ifdef EXT_MEM_STATS_EN
        checkOutput("reset_counts", {rd_cnt, wr_cnt[7:0], err_cnt}, 32'h0);
`endif
        rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0010_0010, 32'h1234_5678);
        stepClock(1); checkOutput("wr_wait1", bus(), 32'b0001);
        stepClock(1); checkOutput("wr_wait2", bus(), 32'b0001);
        stepClock(1); checkOutput("wr_ack_entry", bus(), 32'b0000);
        stepClock(1); checkOutput("wr_ready", bus(), 32'b1000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1); checkOutput("wr_release", bus(), 32'b0000);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0010_0010, 32'h0);
        stepClock(2); checkOutput("rd_wait", bus(), 32'b0001);
        stepClock(1); checkOutput("rd_ack_entry", bus(), 32'b0000);
        stepClock(1); checkOutput("rd_ready", bus(), 32'b1100);
        checkOutput("rd_data", dout, 32'h1234_5678);
        stepClock(1); checkOutput("rd_hold", bus(), 32'b1100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1); checkOutput("rd_release", bus(), 32'b0000);

        runAccess("wr_last", 1'b0, 1'b1, 32'h0010_0FFC, 32'hCAFE_F00D, 32'b1000, 32'h0);
        runAccess("rd_oor", 1'b1, 1'b0, 32'h0010_1000, 32'h0, 32'b1110, 32'hDEAD_BEEF);
        runAccess("wr_below", 1'b0, 1'b1, 32'h000F_FFFC, 32'h1111_1111, 32'b1010, 32'h0);
        runAccess("rd_last", 1'b1, 1'b0, 32'h0010_0FFC, 32'h0, 32'b1100, 32'hCAFE_F00D);
        runAccess("rdwr_both", 1'b1, 1'b1, 32'h0010_0010, 32'h9999_9999, 32'b1110, 32'hDEAD_BEEF);
        runAccess("rd_after_both", 1'b1, 1'b0, 32'h0010_0010, 32'h0, 32'b1100, 32'h1234_5678);

        runAccess("wr_zero", 1'b0, 1'b1, 32'h0010_0020, 32'h0, 32'b1000, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0010_0020, 32'hAAAA_AAAA);
        stepClock(1); checkOutput("abort_wait", bus(), 32'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1); checkOutput("abort_idle", bus(), 32'b0000);
        stepClock(3); checkOutput("abort_no_ready", bus(), 32'b0000);
        runAccess("rd_aborted", 1'b1, 1'b0, 32'h0010_0020, 32'h0, 32'b1100, 32'h0);

        runAccess("wr_w1", 1'b0, 1'b1, 32'h0010_0004, 32'h0000_AAAA, 32'b1000, 32'h0);
        runAccess("wr_w2", 1'b0, 1'b1, 32'h0010_0008, 32'h0000_BBBB, 32'b1000, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0010_0004, 32'h0);
        stepClock(4); checkOutput("rs_first", bus(), 32'b1100);
        checkOutput("rs_first_data", dout, 32'h0000_AAAA);
        addr = 32'h0010_0008;
        stepClock(1); checkOutput("rs_drop", bus(), 32'b0001);
        stepClock(1); checkOutput("rs_wait2", bus(), 32'b0001);
        stepClock(1); checkOutput("rs_entry", bus(), 32'b0000);
        stepClock(1); checkOutput("rs_ready", bus(), 32'b1100);
        checkOutput("rs_data", dout, 32'h0000_BBBB);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1); checkOutput("rs_release", bus(), 32'b0000);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0010_0010, 32'h7777_7777);
        stepClock(1); checkOutput("rst_wait", bus(), 32'b0001);
        rst = 1'b1;
        stepClock(1); checkOutput("rst_bus", bus(), 32'b0000);
        checkOutput("rst_data", dout, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        stepClock(1);

        runAccess("rd_uncommitted", 1'b1, 1'b0, 32'h0010_0010, 32'h0, 32'b1100, 32'h1234_5678);
        runAccess("wr_s1", 1'b0, 1'b1, 32'h0010_0040, 32'h0000_0044, 32'b1000, 32'h0);
        runAccess("wr_s2", 1'b0, 1'b1, 32'h0010_0044, 32'h0000_0045, 32'b1000, 32'h0);
        runAccess("rd_s1", 1'b1, 1'b0, 32'h0010_0040, 32'h0, 32'b1100, 32'h0000_0044);
        runAccess("rd_s2", 1'b1, 1'b0, 32'h0010_0044, 32'h0, 32'b1100, 32'h0000_0045);
        runAccess("rd_err_s", 1'b1, 1'b0, 32'h0020_0000, 32'h0, 32'b1110, 32'hDEAD_BEEF);
`ifdef EXT_MEM_STATS_EN
        checkOutput("rd_count", 32'(rd_cnt), 32'd3);
        checkOutput("wr_count", 32'(wr_cnt), 32'd2);
        checkOutput("err_count", 32'(err_cnt), 32'd1);
        rst = 1'b1;
        stepClock(1);
        checkOutput("counts_cleared", {rd_cnt, wr_cnt[7:0], err_cnt}, 32'h0);
        rst = 1'b0;
        stepClock(1);
`endif

        applyStimulus0(1'b1, 1'b0, 1'b1, 32'h0010_0000, 32'h5A5A_5A5A);
        stepClock(1); checkOutput("z_entry", bus0(), 32'b0000);
        stepClock(1); checkOutput("z_ready", bus0(), 32'b1000);
        din0 = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            stepClock(1); checkOutput("z_wr_hold", bus0(), 32'b1000);
        end
        applyStimulus0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1); checkOutput("z_wr_release", bus0(), 32'b0000);
        applyStimulus0(1'b1, 1'b1, 1'b0, 32'h0010_0000, 32'h0);
        stepClock(2); checkOutput("z_rd_ready", bus0(), 32'b1100);
        checkOutput("z_rd_data", dout0, 32'h5A5A_5A5A);
        for (int i = 0; i < 3; i++) begin
            stepClock(1); checkOutput("z_rd_hold", bus0(), 32'b1100);
        end
        applyStimulus0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepClock(1); checkOutput("z_rd_release", bus0(), 32'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
